instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu16_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 54 +++++
 rtl/instr_fetch.sv | 83 ++++++++
 3 files changed

// File: rtl/cpu16_pkg.sv
// Shared types and constants for the 16-bit CPU front end.
// Imported by the fetch unit and its instruction queue.
package cpu16_pkg;

    typedef logic [15:0] word_t;
    typedef logic [15:0] addr_t;

    localparam addr_t RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        FS_RUN,
        FS_FULL,
        FS_HALT
    } fetch_state_t;

    typedef struct packed {
        addr_t pc;
        word_t data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous instruction FIFO between fetch and decode.
// Head outputs come from registered storage and read zero when empty.
module fetch_queue
    import cpu16_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  entry,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output addr_t         head_pc,
    output word_t         head_data
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    fetch_entry_t  head;

    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head       = mem[rd_ptr];
    assign head_valid = (count != '0);
    assign head_pc    = head_valid ? head.pc : '0;
    assign head_data  = head_valid ? head.data : '0;

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: owns fetch_pc and the fetch FSM, feeds a small queue
// that decouples the combinational ROM from decode.
module instr_fetch
    import cpu16_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT,
    parameter int    QDEPTH   = 2
) (
    input  logic  clk,
    input  logic  rst,
    output addr_t rom_addr,
    input  word_t rom_data,
    output word_t instr,
    output addr_t instr_pc,
    output logic  instr_valid,
    input  logic  instr_ready,
    input  logic  redirect,
    input  addr_t redirect_pc,
    input  logic  halt
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
    localparam logic [CW-1:0] QLAST = CW'(QDEPTH - 1);

    addr_t         fetch_pc;
    fetch_state_t  state;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          fills;

    assign rom_addr = fetch_pc;
    assign pop      = instr_valid && instr_ready;
    assign push     = !redirect && !halt && (count != QFULL || pop);
    // Queue ends this cycle holding QDEPTH entries with nothing leaving
    assign fills    = !pop && (count == QFULL || (push && count == QLAST));

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .entry      ('{pc: fetch_pc, data: rom_data}),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_valid (instr_valid),
        .head_pc    (instr_pc),
        .head_data  (instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            state    <= FS_RUN;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            state    <= FS_RUN;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 16'h0001;
            end
            if (halt) begin
                state <= FS_HALT;
            end else begin
                unique case (state)
                    FS_HALT: state <= FS_RUN;
                    FS_RUN:  state <= fills ? FS_FULL : FS_RUN;
                    FS_FULL: state <= pop ? FS_RUN : FS_FULL;
                    default: state <= FS_RUN;
                endcase
            end
        end
    end

    full_means_full: assert property (
        @(posedge clk) disable iff (rst)
        (state == FS_FULL) |-> (count == QFULL)
    );

endmodule
